// File: rtl/datamem_arbiter.sv
// datamem_arbiter
//   Arbitrates NREQ processing elements onto one single-port data memory.
//   Round-robin search from a rotating pointer; a granted requester that
//   holds its lock bit keeps the memory for up to MAXBURST consecutive
//   grants. Loads return one cycle after the grant, stores commit in the
//   grant cycle.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset      : synchronous, active-low reset
//   req        : per-requester access request
//   lock       : per-requester burst hold, meaningful while req is set
//   we         : per-requester write enable (1 = store, 0 = load)
//   addr       : per-requester word address, requester i at [16i+15:16i]
//   wdata      : per-requester store data, packed like addr
//   gnt        : one-hot-or-zero grant, combinational in the request cycle
//   rvalid     : one-cycle load-data-valid strobe for last cycle's load
//   rdata      : shared load data, valid where rvalid is set
//   mem_en     : memory access strobe
//   mem_we     : memory write enable
//   mem_addr   : memory word address
//   mem_wdata  : memory write data
//   mem_rdata  : memory read data, one cycle after a load strobe
module datamem_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      lock,
  input  logic [NREQ-1:0]      we,
  input  logic [16*NREQ-1:0]   addr,
  input  logic [16*NREQ-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic [15:0]          rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [15:0]          mem_addr,
  output logic [15:0]          mem_wdata,
  input  logic [15:0]          mem_rdata
);

  localparam int         PW        = $clog2(NREQ);
  localparam logic [3:0] BURST_MAX = 4'(MAXBURST);

  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   ptr, ptr_next;
  logic [PW-1:0]   owner, owner_next;
  logic [3:0]      bcnt, bcnt_next, bcnt_inc;
  logic [NREQ-1:0] rvalid_q;
  logic [PW-1:0]   win;
  logic            win_vld;
  logic            owner_holds;

  // Index increment with wrap at NREQ (NREQ need not be a power of two).
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + PW'(1);
  endfunction

  // Round-robin search: scanning from the far end towards ptr and letting
  // each hit overwrite the previous one leaves the requester closest to ptr.
  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; otherwise synthesis infers latches.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        win     = PW'((int'(ptr) + k) % NREQ);
        win_vld = 1'b1;
      end
    end
  end

  assign owner_holds = (state == LOCKED) && req[owner] && lock[owner];
  assign bcnt_inc    = bcnt + 4'd1;

  // Grant and next-state logic. While locked, ptr already points past the
  // owner (set by the grant that entered the burst), so an exit-cycle search
  // naturally puts the former owner last in line.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    owner_next = owner;
    bcnt_next  = bcnt;
    gnt        = '0;

    if (owner_holds) begin
      gnt[owner] = 1'b1;
      bcnt_next  = bcnt_inc;
      if (bcnt_inc >= BURST_MAX) begin
        state_next = ARB;
        ptr_next   = wrap_inc(owner);
      end
    end else begin
      state_next = ARB;
      if (state == LOCKED) begin
        ptr_next = wrap_inc(owner);
      end
      if (win_vld) begin
        gnt[win] = 1'b1;
        ptr_next = wrap_inc(win);
        if (lock[win] && (MAXBURST > 1)) begin
          state_next = LOCKED;
          owner_next = win;
          bcnt_next  = 4'd1;
        end
      end
    end

    // No access may reach memory while reset is asserted.
    if (!reset) begin
      gnt = '0;
    end
  end

  // Memory request mux: route the granted requester's command.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        mem_we    = we[i];
        mem_addr  = addr[16*i +: 16];
        mem_wdata = wdata[16*i +: 16];
      end
    end
  end

  assign mem_en = |gnt;
  assign rdata  = mem_rdata;

  // A load granted just before reset must not surface as rvalid during the
  // reset cycle, so the registered strobe is also gated by reset.
  assign rvalid = rvalid_q & {NREQ{reset}};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ARB;
      ptr      <= '0;
      owner    <= '0;
      bcnt     <= '0;
      rvalid_q <= '0;
    end else begin
      state    <= state_next;
      ptr      <= ptr_next;
      owner    <= owner_next;
      bcnt     <= bcnt_next;
      rvalid_q <= gnt & ~we;
    end
  end

endmodule

// File: tb/tb_datamem_arbiter.sv
// tb_datamem_arbiter
//   Directed scenarios followed by randomized traffic, all checked against a
//   behavioural model of the arbitration rules and a reference memory.
module tb_datamem_arbiter;

  localparam int NREQ     = 4;
  localparam int MAXBURST = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req, lock, we;
  logic [16*NREQ-1:0]   addr, wdata;
  logic [NREQ-1:0]      gnt, rvalid;
  logic [15:0]          rdata;
  logic                 mem_en, mem_we;
  logic [15:0]          mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  datamem_arbiter #(.NREQ(NREQ), .MAXBURST(MAXBURST)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory behind the DUT (answers the DUT's strobes) and the reference copy
  // (updated by the model's expected transfers). Indexed by the low address byte.
  logic [15:0] ram     [256];
  logic [15:0] ref_mem [256];

  // Behavioural model: a lock holder keeps the memory while it asks, for at
  // most MAXBURST grants; otherwise the first requester at or after the
  // round-robin pointer wins.
  int              m_ptr    = 0;
  bit              m_locked = 1'b0;
  int              m_owner  = 0;
  int              m_left   = 0;
  logic [NREQ-1:0] m_rv     = '0;
  logic [15:0]     m_rdata  = '0;
  logic [NREQ-1:0] sticky   = '0;

  logic [NREQ-1:0] obs_gnt, obs_rvalid;
  logic [15:0]     obs_rdata, obs_mem_addr, obs_mem_wdata;
  logic            obs_mem_en, obs_mem_we;

  function automatic int model_pick();
    if (!reset) return -1;
    if (m_locked && req[m_owner] && lock[m_owner]) return m_owner;
    for (int k = 0; k < NREQ; k++) begin
      if (req[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_commit(input int g);
    if (!reset) begin
      m_locked = 1'b0;
      m_ptr    = 0;
      m_owner  = 0;
      m_rv     = '0;
      return;
    end
    m_rv = '0;
    if (g >= 0) begin
      if (we[g]) ref_mem[addr[16*g +: 8]] = wdata[16*g +: 16];
      else begin
        m_rv[g] = 1'b1;
        m_rdata = ref_mem[addr[16*g +: 8]];
      end
    end
    if (m_locked && g == m_owner && lock[m_owner]) begin
      m_left--;
      if (m_left == 0) begin
        m_locked = 1'b0;
        m_ptr    = (m_owner + 1) % NREQ;
      end
    end else begin
      if (m_locked) begin
        m_locked = 1'b0;
        m_ptr    = (m_owner + 1) % NREQ;
      end
      if (g >= 0) begin
        m_ptr = (g + 1) % NREQ;
        if (lock[g] && MAXBURST > 1) begin
          m_locked = 1'b1;
          m_owner  = g;
          m_left   = MAXBURST - 1;
        end
      end
    end
  endtask

  task automatic load_req(input int i, input logic w, input logic [15:0] a, input logic [15:0] d);
    req[i]            = 1'b1;
    we[i]             = w;
    addr[16*i +: 16]  = a;
    wdata[16*i +: 16] = d;
  endtask

  // One clock cycle: inputs were set just after the previous rising edge;
  // outputs are checked at the falling edge, then the model and memory advance.
  task automatic step();
    int              g;
    logic [NREQ-1:0] eg, erv;
    logic            d_en, d_we;
    logic [15:0]     d_a, d_d;
    g   = model_pick();
    eg  = (g >= 0) ? (NREQ'(1) << g) : '0;
    erv = reset ? m_rv : '0;
    @(negedge clk);
    obs_gnt       = gnt;
    obs_rvalid    = rvalid;
    obs_rdata     = rdata;
    obs_mem_en    = mem_en;
    obs_mem_we    = mem_we;
    obs_mem_addr  = mem_addr;
    obs_mem_wdata = mem_wdata;
    check("gnt", obs_gnt, eg);
    check("gnt_in_req", obs_gnt & ~req, '0);
    check("mem_en", obs_mem_en, (g >= 0));
    if (g >= 0) begin
      check("mem_we", obs_mem_we, we[g]);
      check("mem_addr", obs_mem_addr, addr[16*g +: 16]);
      check("mem_wdata", obs_mem_wdata, wdata[16*g +: 16]);
    end else begin
      check("mem_we_idle", obs_mem_we, 1'b0);
    end
    check("rvalid", obs_rvalid, erv);
    if (erv != '0) check("rdata", obs_rdata, m_rdata);
    d_en = mem_en;
    d_we = mem_we;
    d_a  = mem_addr;
    d_d  = mem_wdata;
    @(posedge clk);
    #1;
    model_commit(g);
    if (d_en && d_we) ram[d_a[7:0]] = d_d;
    mem_rdata = (d_en && !d_we) ? ram[d_a[7:0]] : 16'($urandom);
    if (g >= 0 && !sticky[g]) req[g] = 1'b0;
  endtask

  task automatic idle();
    req    = '0;
    lock   = '0;
    sticky = '0;
  endtask

  initial begin
    logic [NREQ-1:0] exp3 [6];
    exp3 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};

    for (int i = 0; i < 256; i++) begin
      ram[i]     = 16'($urandom);
      ref_mem[i] = ram[i];
    end
    reset = 1'b0; req = '0; lock = '0; we = '0;
    addr = '0; wdata = '0; mem_rdata = '0;
    @(posedge clk);
    #1;

    // Reset state
    step();
    step();
    check("rst_gnt", obs_gnt, '0);
    check("rst_mem_en", obs_mem_en, 1'b0);
    check("rst_rvalid", obs_rvalid, '0);

    // Plain round robin with everyone requesting
    reset = 1'b1;
    sticky = 4'b1111;
    for (int i = 0; i < NREQ; i++) load_req(i, 1'b0, 16'(i * 4), 16'h0);
    for (int k = 0; k < 8; k++) begin
      step();
      check("rr_seq", obs_gnt, 4'b0001 << (k % 4));
      check("rr_mem_en", obs_mem_en, 1'b1);
    end
    idle();
    step();

    // Single load with one-cycle latency
    ram[8'h40] = 16'hBEEF;
    ref_mem[8'h40] = 16'hBEEF;
    load_req(2, 1'b0, 16'h0040, 16'h0);
    step();
    check("ld_gnt", obs_gnt, 4'b0100);
    step();
    check("ld_rvalid", obs_rvalid, 4'b0100);
    check("ld_rdata", obs_rdata, 16'hBEEF);
    step();
    check("ld_rvalid_clr", obs_rvalid, '0);

    // Burst limit then fairness
    reset = 1'b0;
    step();
    reset = 1'b1;
    sticky = 4'b0011;
    load_req(0, 1'b0, 16'h0010, 16'h0);
    load_req(1, 1'b1, 16'h0020, 16'h5A5A);
    lock = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      step();
      check("burst_seq", obs_gnt, exp3[k]);
    end
    idle();
    step();

    // Lock dropped mid-burst while another requester waits
    reset = 1'b0;
    step();
    reset = 1'b1;
    sticky = 4'b0010;
    load_req(1, 1'b0, 16'h0031, 16'h0);
    load_req(3, 1'b0, 16'h0033, 16'h0);
    lock = 4'b0010;
    step();
    check("drop_c1", obs_gnt, 4'b0010);
    step();
    check("drop_c2", obs_gnt, 4'b0010);
    lock = '0;
    step();
    check("drop_c3", obs_gnt, 4'b1000);
    sticky = '0;
    load_req(0, 1'b0, 16'h0030, 16'h0);
    step();
    check("drop_ptr0", obs_gnt, 4'b0001);
    idle();
    step();
    step();

    // Store from requester 3
    load_req(3, 1'b1, 16'h1234, 16'h00A5);
    step();
    check("st_gnt", obs_gnt, 4'b1000);
    check("st_mem_en", obs_mem_en, 1'b1);
    check("st_mem_we", obs_mem_we, 1'b1);
    check("st_mem_addr", obs_mem_addr, 16'h1234);
    check("st_mem_wdata", obs_mem_wdata, 16'h00A5);
    step();
    check("st_no_rvalid", obs_rvalid, '0);

    // Reset in the middle of a locked load burst
    sticky = 4'b0001;
    load_req(0, 1'b0, 16'h0050, 16'h0);
    lock = 4'b0001;
    step();
    step();
    reset = 1'b0;
    step();
    check("mid_rst_gnt", obs_gnt, '0);
    check("mid_rst_mem_en", obs_mem_en, 1'b0);
    check("mid_rst_rvalid", obs_rvalid, '0);
    reset = 1'b1;
    idle();
    load_req(1, 1'b0, 16'h0061, 16'h0);
    load_req(3, 1'b0, 16'h0063, 16'h0);
    step();
    check("post_rst_gnt", obs_gnt, 4'b0010);
    check("post_rst_rvalid", obs_rvalid, '0);
    idle();
    step();
    step();

    // Randomized traffic: requests stay stable until granted, lock toggles
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0)
          load_req(i, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      end
      lock = NREQ'($urandom | $urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
